// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: opcodes, FSM encoding and chunk-counter sizing for alu_serial
package alu_serial_pkg;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic int cnt_width(input int chunks);
        return chunks > 1 ? $clog2(chunks) : 1;
    endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational one-bit ALU slice with ripple carry for ADD/SUB
module alu_bit_slice
    import alu_serial_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] control,
    output logic       out,
    output logic       cout
);
    logic arith;
    assign arith = control == ALU_ADD || control == ALU_SUB;
    assign out   = arith ? a ^ b ^ cin :
                   control == ALU_AND ? a & b :
                   control == ALU_OR  ? a | b :
                   control == ALU_NOR ? ~(a | b) :
                   control == ALU_XOR ? a ^ b : 1'b0;
    assign cout  = arith & ((a & b) | (cin & (a ^ b)));
endmodule

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU iterating BPC-bit chunks LSB first with valid/ready handshakes
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_width(N);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_nx;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry, last, arith;
    logic [BPC:0]     c;
    logic [BPC-1:0]   s, bsl;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign last      = cnt == CW'(N - 1);
    assign arith     = op_q == ALU_ADD || op_q == ALU_SUB;
    assign bsl       = op_q == ALU_SUB ? ~b_q[BPC-1:0] : b_q[BPC-1:0];
    assign c[0]      = carry;
    assign res_nx    = WIDTH'({s, out} >> BPC);

    for (genvar i = 0; i < BPC; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a      (a_q[i]),
            .b      (bsl[i]),
            .cin    (c[i]),
            .control(op_q),
            .out    (s[i]),
            .cout   (c[i+1])
        );
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? BUSY : IDLE) :
                   state == BUSY ? (last ? DONE : BUSY) :
                   (out_ready ? IDLE : DONE);
    end

    // the result shifts in from the MSB side, so it is aligned once all N chunks are in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            out      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= control;
                cnt   <= '0;
                carry <= control == ALU_SUB;
            end
            if (state == BUSY) begin
                a_q   <= a_q >> BPC;
                b_q   <= b_q >> BPC;
                out   <= res_nx;
                carry <= c[BPC];
                cnt   <= CW'(cnt + 1'b1);
                if (last) begin
                    cout     <= arith & c[BPC];
                    overflow <= arith & (c[BPC] ^ c[BPC-1]);
                    zero     <= res_nx == '0;
                    negative <= res_nx[WIDTH-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed self-checking bench for alu_serial (32/1 and 8/4 configurations)
module tb_alu_serial;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
    logic [31:0] A = '0, B = '0, out;
    logic [2:0]  control = '0;
    logic        cout, overflow, zero, negative;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0, in_ready2, out_valid2;
    logic [7:0]  a2 = '0, b2 = '0, out2;
    logic [2:0]  control2 = '0;
    logic        cout2, overflow2, zero2, negative2;

    int tests = 0, failed = 0, lat;
    logic [31:0] hold_out;

    alu_serial #(.WIDTH(32), .BPC(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    alu_serial #(.WIDTH(8), .BPC(4)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .control(control2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out(out2), .cout(cout2), .overflow(overflow2), .zero(zero2), .negative(negative2)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
        A = a;
        B = b;
        control = ctl;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] ctl, input logic [31:0] exp_out, input logic [3:0] exp_flags);
        int l;
        start_op(a, b, ctl);
        wait_done(l);
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_flags"}, {28'd0, cout, overflow, zero, negative}, {28'd0, exp_flags});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", {28'd0, cout, overflow, zero, negative}, 32'd0);
        reset = 1'b1;
        tick();

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd2);
        wait_done(lat);
        chk("add_ovf_latency", lat, 32'd32);
        chk("add_ovf_out", out, 32'h8000_0000);
        chk("add_ovf_flags", {28'd0, cout, overflow, zero, negative}, 32'b0101);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 32'h0000_0000, 4'b1010);
        run_op("sub_eq",   32'h0000_0005, 32'h0000_0005, 3'd3, 32'h0000_0000, 4'b1010);
        run_op("sub_neg",  32'h0000_0000, 32'h0000_0001, 3'd3, 32'hFFFF_FFFF, 4'b0001);
        run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'd3, 32'h7FFF_FFFF, 4'b1100);
        run_op("and",      32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000, 4'b0001);
        run_op("or",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'hFFF0_FFF0, 4'b0001);
        run_op("nor",      32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 32'h000F_000F, 4'b0000);
        run_op("xor",      32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'h0FF0_0FF0, 4'b0000);
        run_op("ctl1",     32'hF0F0_F0F0, 32'hFF00_FF00, 3'd1, 32'h0000_0000, 4'b0010);
        run_op("ctl0",     32'h1234_5678, 32'h1111_1111, 3'd0, 32'h0000_0000, 4'b0010);

        start_op(32'h0000_0001, 32'h0000_0002, 3'd2);
        wait_done(lat);
        chk("bp_out", out, 32'h0000_0003);
        A = 32'd10;
        B = 32'd20;
        control = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_out", out, 32'h0000_0003);
            chk("bp_hold_valid", {30'd0, out_valid, in_ready}, 32'b10);
        end
        chk("bp_hold_flags", {28'd0, cout, overflow, zero, negative}, 32'b0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_bubble", {30'd0, out_valid, in_ready}, 32'b01);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", {30'd0, out_valid, in_ready}, 32'b00);
        wait_done(lat);
        chk("bp_next_latency", lat, 32'd32);
        chk("bp_next_out", out, 32'd30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        start_op(32'h0000_1234, 32'h0000_4321, 3'd2);
        repeat (10) tick();
        hold_out = out;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", {30'd0, out_valid, in_ready}, 32'b01);
        chk("rst_mid_out", out, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        start_op(32'd3, 32'd4, 3'd2);
        wait_done(lat);
        chk("post_rst_latency", lat, 32'd32);
        chk("post_rst_out", out, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        a2 = 8'hFF;
        b2 = 8'h01;
        control2 = 3'd2;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            tick();
            lat++;
        end
        chk("w8_latency", lat, 32'd2);
        chk("w8_out", {24'd0, out2}, 32'h0000_0000);
        chk("w8_flags", {28'd0, cout2, overflow2, zero2, negative2}, 32'b1010);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk("w8_idle", {30'd0, out_valid2, in_ready2}, 32'b01);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
